// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, frame geometry and line levels.
`timescale 1ns/1ps
package uart_pkg;

    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned BIT_IDX_W = $clog2(DATA_BITS);

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_e;

endpackage

// File: rtl/uart_tx_if.sv
// Request/serial-line bundle between the result path (master) and uart_tx (slave).
`timescale 1ns/1ps
interface uart_tx_if;
    import uart_pkg::*;

    logic                 uout_valid;
    logic [DATA_BITS-1:0] tx_data;
    logic                 txd;
    logic                 tx_valid;

    modport master (
        output uout_valid,
        output tx_data,
        input  txd,
        input  tx_valid
    );

    modport slave (
        input  uout_valid,
        input  tx_data,
        output txd,
        output tx_valid
    );

endinterface

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: emits a one-cycle bit_done_o tick every CLKS_PER_BIT clocks.
`timescale 1ns/1ps
module uart_baud_cnt #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    output logic bit_done_o
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr_i || cnt_q == CNT_MAX) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bit_done_o = !clr_i && (cnt_q == CNT_MAX);

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: one byte per level request, fixed CLKS_PER_BIT bit timing.
`timescale 1ns/1ps
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    uart_tx_if.slave   bus
);

    uart_state_e          state_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [BIT_IDX_W-1:0] bit_idx_q;
    logic                 txd_q;
    logic                 tx_valid_q;
    logic                 baud_clr;
    logic                 bit_done;

    // Counter is held at zero in IDLE so every frame begins on a full bit period.
    assign baud_clr = (state_q == IDLE);

    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_cnt (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (baud_clr),
        .bit_done_o(bit_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            txd_q      <= LINE_IDLE;
            tx_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.uout_valid) begin
                        shift_q    <= bus.tx_data;
                        txd_q      <= START_BIT;
                        tx_valid_q <= 1'b1;
                        state_q    <= START;
                    end
                end
                START: begin
                    if (bit_done) begin
                        bit_idx_q <= '0;
                        txd_q     <= shift_q[0];
                        state_q   <= DATA;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        if (bit_idx_q == BIT_IDX_W'(DATA_BITS - 1)) begin
                            txd_q   <= LINE_IDLE;
                            state_q <= STOP;
                        end else begin
                            // Next line level comes from bit 1 since the shift lands on the same edge.
                            bit_idx_q <= bit_idx_q + 1'b1;
                            shift_q   <= shift_q >> 1;
                            txd_q     <= shift_q[1];
                        end
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        tx_valid_q <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: begin
                    txd_q      <= LINE_IDLE;
                    tx_valid_q <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    assign bus.txd      = txd_q;
    assign bus.tx_valid = tx_valid_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx with N=16: reset, single/held frames, mid-frame changes, extremes.
`timescale 1ns/1ps
module tb_uart_tx;

    localparam int unsigned N = 16;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    uart_tx_if bus ();

    uart_tx #(
        .CLKS_PER_BIT(N)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Called at cycle k (just after the start edge). pat holds the 10 line levels, index 0 first.
    // At frame-relative cycle chg (if >= 0) the request is dropped and tx_data changed to 0x00.
    task automatic check_frame(input string tag, input logic [9:0] pat, input int chg);
        for (int c = 0; c < 10 * N; c++) begin
            if (c == chg) begin
                bus.tx_data    = 8'h00;
                bus.uout_valid = 1'b0;
            end
            check($sformatf("%s txd c%0d", tag, c), bus.txd, pat[c / N]);
            check($sformatf("%s valid c%0d", tag, c), bus.tx_valid, 1);
            next_cycle();
        end
        check($sformatf("%s end txd", tag), bus.txd, 1);
        check($sformatf("%s end valid", tag), bus.tx_valid, 0);
    endtask

    task automatic check_quiet(input string tag, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            next_cycle();
            check($sformatf("%s txd c%0d", tag, c), bus.txd, 1);
            check($sformatf("%s valid c%0d", tag, c), bus.tx_valid, 0);
        end
    endtask

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        rst            = 1'b0;
        bus.uout_valid = 1'b1;
        bus.tx_data    = 8'hAB;
        #1 rst = 1'b1;

        // Reset held with a pending request: line stays idle.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("rst txd %0d", i), bus.txd, 1);
            check($sformatf("rst valid %0d", i), bus.tx_valid, 0);
        end

        // Release: frame starts at the first edge; request then dropped (single pulse).
        rst = 1'b0;
        next_cycle();
        bus.uout_valid = 1'b0;
        check_frame("ab_single", 10'b1101010110, -1);
        check_quiet("ab_single idle", 20);

        // Held request: back-to-back frames separated by one idle cycle.
        @(negedge clk);
        bus.uout_valid = 1'b1;
        bus.tx_data    = 8'hAB;
        next_cycle();
        check_frame("ab_held1", 10'b1101010110, -1);
        next_cycle();
        // Second frame: data and request change during DATA, frame must still carry 0xAB.
        check_frame("ab_held2", 10'b1101010110, 4 * N + 5);
        check_quiet("after_held idle", 30);

        // Reset in the middle of data bit 3 of 0xA5 (bit 3 is 0).
        @(negedge clk);
        bus.uout_valid = 1'b1;
        bus.tx_data    = 8'hA5;
        next_cycle();
        bus.uout_valid = 1'b0;
        for (int i = 0; i < 4 * N + 3; i++) next_cycle();
        check("a5 bit3 txd", bus.txd, 0);
        check("a5 bit3 valid", bus.tx_valid, 1);
        #2 rst = 1'b1;
        #1;
        check("async rst txd", bus.txd, 1);
        check("async rst valid", bus.tx_valid, 0);
        @(negedge clk);
        @(negedge clk);
        rst            = 1'b0;
        bus.uout_valid = 1'b1;
        next_cycle();
        bus.uout_valid = 1'b0;
        check_frame("a5_fresh", 10'b1101001010, -1);
        check_quiet("a5 idle", 5);

        // Extremes.
        @(negedge clk);
        bus.uout_valid = 1'b1;
        bus.tx_data    = 8'h00;
        next_cycle();
        bus.uout_valid = 1'b0;
        check_frame("x00", 10'b1000000000, -1);
        check_quiet("x00 idle", 5);

        @(negedge clk);
        bus.uout_valid = 1'b1;
        bus.tx_data    = 8'hFF;
        next_cycle();
        bus.uout_valid = 1'b0;
        check_frame("xff", 10'b1111111110, -1);
        check_quiet("xff idle", 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
